// File: rtl/ahb_stream_wr_master.sv
// AHB-Lite write master: drains a valid/ready stream of 32-bit words into
// memory as INCR bursts, inserting BUSY when the stream stalls.
module ahb_stream_wr_master #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic [31:0]       hwdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] HT_IDLE = 2'd0;
  localparam logic [1:0] HT_BUSY = 2'd1;
  localparam logic [1:0] HT_NSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              first_q, first_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic              dph_q, dph_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  assign s_ready = (state_q == S_ADDR) && hready && (rem_q != '0);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    first_d  = first_q;
    wdat_d   = wdat_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwdata_d = hwdata_q;
    dph_d    = dph_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    // dph_q marks a cycle carrying the data phase of a real (NONSEQ/SEQ) beat
    if (hready) dph_d = htrans_q[1];
    if (dph_q && (hresp != 2'b00)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cfg_start && !done_q) begin
          addr_d  = cfg_addr & ~ADDR_W'(3);
          rem_d   = cfg_len;
          first_d = 1'b1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = (cfg_len == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (hready) begin
          hwdata_d = wdat_q;
          if (s_valid && s_ready) begin
            haddr_d  = addr_q;
            wdat_d   = s_data;
            // restart the burst at every 1 KB boundary
            htrans_d = (first_q || (addr_q[9:0] == 10'd0)) ? HT_NSEQ : HT_SEQ;
            addr_d   = addr_q + ADDR_W'(4);
            rem_d    = rem_q - LEN_W'(1);
            first_d  = 1'b0;
            if (rem_q == LEN_W'(1)) state_d = S_LAST;
          end else begin
            htrans_d = first_q ? HT_IDLE : HT_BUSY;
          end
        end
      end
      S_LAST: begin
        if (hready) begin
          htrans_d = HT_IDLE;
          hwdata_d = wdat_q;
          state_d  = S_DONE;
        end
      end
      default: begin
        if (hready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      first_q  <= 1'b0;
      wdat_q   <= '0;
      haddr_q  <= '0;
      htrans_q <= HT_IDLE;
      hwdata_q <= '0;
      dph_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      wdat_q   <= wdat_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwdata_q <= hwdata_d;
      dph_q    <= dph_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign hsel   = busy_q;
  assign hwrite = busy_q;
  assign haddr  = haddr_q;
  assign htrans = htrans_q;
  assign hwdata = hwdata_q;
  assign hsize  = 3'b010;
  assign hburst = 3'b001;
  assign hprot  = 4'b0011;

endmodule

// File: tb/tb_ahb_stream_wr_master.sv
// Directed bench for ahb_stream_wr_master with a small SRAM slave model and
// a counting stream source (word n carries 0xD00D0000+n).
module tb_ahb_stream_wr_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_start;
  logic [11:0] cfg_addr;
  logic [15:0] cfg_len;
  logic        busy, done, err;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        hsel;
  logic [11:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic [1:0]  hresp;

  int total = 0;
  int bad   = 0;

  ahb_stream_wr_master #(.ADDR_W(12), .LEN_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  // stream source: each accepted word advances the counter
  logic [15:0] cnt = 16'd0;
  assign s_data = {16'hD00D, cnt};
  always @(posedge clk) if (s_valid && s_ready) cnt <= cnt + 16'd1;

  // SRAM slave model: address phase captured, written in the data phase
  logic [31:0] mem [0:1023];
  logic        dph_v = 1'b0;
  logic [9:0]  dph_a = 10'd0;
  always @(posedge clk) begin
    if (hready) begin
      if (dph_v) mem[dph_a] <= hwdata;
      dph_v <= hsel && htrans[1];
      dph_a <= haddr[11:2];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [11:0] a, input logic [15:0] l);
    cfg_addr  = a;
    cfg_len   = l;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; cfg_start = 1'b0; cfg_addr = '0; cfg_len = '0;
    s_valid = 1'b0; hready = 1'b1; hresp = 2'b00;
    tick(); tick();
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hsel", 32'(hsel), 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_haddr", 32'(haddr), 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("const_hsize", 32'(hsize), 32'd2);
    chk("const_hburst", 32'(hburst), 32'd1);
    chk("const_hprot", 32'(hprot), 32'd3);
    rstn = 1'b1;
    tick();

    // T1: 4 beats from 0x010, stream always valid
    s_valid = 1'b1;
    start(12'h010, 16'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_hsel", 32'(hsel), 32'd1);
    chk("t1_htrans0", 32'(htrans), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_htrans", 32'(htrans), (k == 0) ? 32'd2 : 32'd3);
      chk("t1_haddr", 32'(haddr), 32'h010 + 32'(4 * k));
      if (k > 0) chk("t1_hwdata", hwdata, 32'hD00D0000 + 32'(k - 1));
      chk("t1_done_lo", 32'(done), 32'd0);
    end
    tick();
    chk("t1_last_htrans", 32'(htrans), 32'd0);
    chk("t1_last_hwdata", hwdata, 32'hD00D0003);
    chk("t1_done_early", 32'(done), 32'd0);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) chk("t1_mem", mem[4 + k], 32'hD00D0000 + 32'(k));

    // T2: 6 beats, stream stalls 2 cycles after the second beat
    start(12'h100, 16'd6);
    tick(); chk("t2_b0", 32'(htrans), 32'd2);
    tick(); chk("t2_b1", 32'(htrans), 32'd3);
    s_valid = 1'b0;
    tick(); chk("t2_busy1", 32'(htrans), 32'd1); chk("t2_haddr_hold", 32'(haddr), 32'h104);
    tick(); chk("t2_busy2", 32'(htrans), 32'd1); chk("t2_busy_flag", 32'(busy), 32'd1);
    s_valid = 1'b1;
    tick(); chk("t2_b2", 32'(htrans), 32'd3); chk("t2_b2_addr", 32'(haddr), 32'h108);
    tick(); tick(); tick();
    chk("t2_b5_addr", 32'(haddr), 32'h114);
    chk("t2_busy_mid", 32'(busy), 32'd1);
    tick(); tick();
    chk("t2_done", 32'(done), 32'd1);
    tick();
    for (int k = 0; k < 6; k++) chk("t2_mem", mem[10'h40 + 10'(k)], 32'hD00D0004 + 32'(k));

    // T3: 1 KB boundary restarts the burst; error response on beat 0 data phase
    start(12'h3F8, 16'd4);
    tick(); chk("t3_b0", 32'(htrans), 32'd2);
    tick(); chk("t3_b1", 32'(htrans), 32'd3);
    hresp = 2'b01;
    tick(); chk("t3_b2", 32'(htrans), 32'd2); chk("t3_b2_addr", 32'(haddr), 32'h400);
    chk("t3_err", 32'(err), 32'd1);
    hresp = 2'b00;
    tick(); chk("t3_b3", 32'(htrans), 32'd3); chk("t3_b3_addr", 32'(haddr), 32'h404);
    tick(); tick();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_err_sticky", 32'(err), 32'd1);
    tick();

    // T4: address wrap at top of the space; start clears err
    start(12'hFFC, 16'd2);
    chk("t4_err_clr", 32'(err), 32'd0);
    tick(); chk("t4_b0_addr", 32'(haddr), 32'hFFC);
    tick(); chk("t4_b1_addr", 32'(haddr), 32'h000); chk("t4_b1_nseq", 32'(htrans), 32'd2);
    tick(); tick();
    chk("t4_done", 32'(done), 32'd1);
    tick();
    chk("t4_mem0", mem[0], 32'hD00D000F);

    // T5: hready low for 3 cycles mid-burst
    start(12'h200, 16'd4);
    tick(); tick();
    hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_haddr_frz", 32'(haddr), 32'h204);
      chk("t5_htrans_frz", 32'(htrans), 32'd3);
      chk("t5_hwdata_frz", hwdata, 32'hD00D0010);
      chk("t5_sready", 32'(s_ready), 32'd0);
    end
    hready = 1'b1;
    tick(); chk("t5_b2_addr", 32'(haddr), 32'h208); chk("t5_b2_wd", hwdata, 32'hD00D0011);
    tick(); tick(); tick();
    chk("t5_done", 32'(done), 32'd1);
    tick();
    for (int k = 0; k < 4; k++) chk("t5_mem", mem[10'h80 + 10'(k)], 32'hD00D0010 + 32'(k));

    // T6: zero-length job, then a start coinciding with done is dropped
    start(12'h040, 16'd0);
    chk("t6_htrans", 32'(htrans), 32'd0);
    chk("t6_done_early", 32'(done), 32'd0);
    cfg_start = 1'b1;
    tick();
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_htrans_idle", 32'(htrans), 32'd0);
    tick();
    cfg_start = 1'b0;
    chk("t6_start_ignored", 32'(busy), 32'd0);
    tick();
    chk("t6_still_idle", 32'(busy), 32'd0);

    // T7: reset mid-burst after an error
    start(12'h300, 16'd4);
    tick(); tick();
    hresp = 2'b10;
    tick();
    hresp = 2'b00;
    chk("t7_err_set", 32'(err), 32'd1);
    rstn = 1'b0; s_valid = 1'b0;
    tick();
    chk("t7_htrans", 32'(htrans), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_err", 32'(err), 32'd0);
    rstn = 1'b1; s_valid = 1'b1;
    tick(); tick();
    chk("t7_no_beat", 32'(htrans), 32'd0);
    chk("t7_sready", 32'(s_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
